// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and widths for the PLL reset sequencer.
//   pll_seq_state_t : sequencer state encoding, also exported on the status port
//   RETRY_W, LOST_W : widths of the retry and lock-loss counters
//   max3()          : elaboration-time helper for sizing the shared timer
package pll_seq_pkg;

    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOST_W  = 8;

    typedef enum logic [2:0] {
        StResetPll  = 3'd0,
        StWaitLock  = 3'd1,
        StStabilize = 3'd2,
        StRun       = 3'd3,
        StFail      = 3'd4
    } pll_seq_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
//   pll_locked    : raw PLL lock, asynchronous to refclk
//   relock_req    : single-cycle request to restart the sequence
//   pll_rst       : active-high PLL reset
//   sys_rst_n     : active-low downstream reset, high only while running
//   fail          : lock retries exhausted
//   state         : current sequencer state
//   retry_cnt     : retries used in the current attempt
//   lock_lost_cnt : saturating count of lock losses while running
// master is the sequencer side, slave is the board/software side.
interface pll_reset_sequencer_if;
    import pll_seq_pkg::*;

    logic                pll_locked;
    logic                relock_req;
    logic                pll_rst;
    logic                sys_rst_n;
    logic                fail;
    pll_seq_state_t      state;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [LOST_W-1:0]   lock_lost_cnt;

    modport master (
        input  pll_locked, relock_req,
        output pll_rst, sys_rst_n, fail, state, retry_cnt, lock_lost_cnt
    );

    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, sys_rst_n, fail, state, retry_cnt, lock_lost_cnt
    );

endinterface

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input
//   q     : synchronized output, STAGES destination edges behind d
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Board PLL reset sequencer, clocked by the PLL reference clock.
// Pulses the PLL reset, waits for lock with a bounded number of retries, requires
// the lock to stay up for a qualification window, then releases the downstream
// reset. Lock loss while running restarts the sequence; software can force a
// restart at any time with relock_req.
//   refclk : reference clock, valid before lock
//   rst_n  : asynchronous active-low reset
//   bus    : control/status bundle (master side), see pll_reset_sequencer_if
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned SYNC_STAGES         = 2
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    pll_reset_sequencer_if.master  bus
);

    localparam int unsigned MAX_CYCLES =
        max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int unsigned TIMER_W = $clog2(MAX_CYCLES) + 1;

    // Terminal timer values: each timed state lasts exactly N cycles.
    localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    logic                locked_sync;
    pll_seq_state_t      state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [LOST_W-1:0]   lost_q, lost_d;
    logic                pll_rst_q, sys_rst_n_q, fail_q;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (locked_sync)
    );

    // Next state; relock_req beats lock loss, which beats timer expiry.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;

        if (bus.relock_req) begin
            state_d = StResetPll;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StResetPll: begin
                    if (timer_q == HOLD_LAST) begin
                        state_d = StWaitLock;
                    end
                end
                StWaitLock: begin
                    if (locked_sync) begin
                        state_d = StStabilize;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = StFail;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            state_d = StResetPll;
                        end
                    end
                end
                StStabilize: begin
                    // A dropout here is a glitch: back to waiting, no retry consumed.
                    if (!locked_sync) begin
                        state_d = StWaitLock;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = StRun;
                        retry_d = '0;
                    end
                end
                StRun: begin
                    if (!locked_sync) begin
                        state_d = StResetPll;
                        if (lost_q != '1) begin
                            lost_d = lost_q + 1'b1;
                        end
                    end
                end
                StFail: begin
                    state_d = StFail;
                end
                default: begin
                    state_d = StResetPll;
                end
            endcase
        end

        // Shared timer: restarts on any transition (or relock), and only runs in
        // the timed states so it can never wrap.
        timer_d = '0;
        if (!bus.relock_req && (state_d == state_q) &&
            (state_q inside {StResetPll, StWaitLock, StStabilize})) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StResetPll;
            timer_q     <= '0;
            retry_q     <= '0;
            lost_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            // Outputs decoded from next state so they move on the same edge as state.
            pll_rst_q   <= (state_d == StResetPll) || (state_d == StFail);
            sys_rst_n_q <= (state_d == StRun);
            fail_q      <= (state_d == StFail);
        end
    end

    assign bus.state         = state_q;
    assign bus.pll_rst       = pll_rst_q;
    assign bus.sys_rst_n     = sys_rst_n_q;
    assign bus.fail          = fail_q;
    assign bus.retry_cnt     = retry_q;
    assign bus.lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    localparam int unsigned HOLD = 4;
    localparam int unsigned TO   = 20;
    localparam int unsigned STB  = 8;
    localparam int unsigned MR   = 2;
    localparam int unsigned SS   = 2;

    logic refclk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_bad   = 0;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES     (HOLD),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (STB),
        .MAX_RETRIES         (MR),
        .SYNC_STAGES         (SS)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: absolute edge count with per-state deadlines and a queue
    // as the lock synchronizer delay line.
    pll_seq_state_t m_st;
    int             m_cyc, m_entry, m_retry, m_lost;
    bit             m_pipe[$];

    task automatic m_enter(input pll_seq_state_t s);
        m_st    = s;
        m_entry = m_cyc;
    endtask

    task automatic model_step();
        bit ls;
        if (!rst_n) begin
            m_st = StResetPll; m_cyc = 0; m_entry = 0; m_retry = 0; m_lost = 0;
            m_pipe = {};
            for (int i = 0; i < SS; i++) m_pipe.push_back(1'b0);
            return;
        end
        m_cyc++;
        ls = m_pipe.pop_front();
        m_pipe.push_back(bus.pll_locked);
        if (bus.relock_req) begin
            m_retry = 0;
            m_enter(StResetPll);
        end else begin
            case (m_st)
                StResetPll: if (m_cyc == m_entry + HOLD) m_enter(StWaitLock);
                StWaitLock: begin
                    if (ls) m_enter(StStabilize);
                    else if (m_cyc == m_entry + TO) begin
                        if (m_retry == MR) m_enter(StFail);
                        else begin m_retry++; m_enter(StResetPll); end
                    end
                end
                StStabilize: begin
                    if (!ls) m_enter(StWaitLock);
                    else if (m_cyc == m_entry + STB) begin m_retry = 0; m_enter(StRun); end
                end
                StRun: if (!ls) begin
                    if (m_lost < 255) m_lost++;
                    m_enter(StResetPll);
                end
                default: ;
            endcase
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge refclk);
            model_step();
            #1;
            check_eq("mon_state", int'(bus.state), int'(m_st));
            check_eq("mon_pll_rst", int'(bus.pll_rst), int'(m_st inside {StResetPll, StFail}));
            check_eq("mon_sys_rst_n", int'(bus.sys_rst_n), int'(m_st == StRun));
            check_eq("mon_fail", int'(bus.fail), int'(m_st == StFail));
            check_eq("mon_retry", int'(bus.retry_cnt), m_retry);
            check_eq("mon_lost", int'(bus.lock_lost_cnt), m_lost);
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_state(input pll_seq_state_t s, input int budget, input string tag);
        int n = 0;
        while (bus.state != s && n < budget) begin
            @(posedge refclk); #1; n++;
        end
        check_eq({tag, "_reached"}, int'(bus.state == s), 1);
        @(negedge refclk);
    endtask

    // Leaves the caller 1 time unit after the edge that sampled the request.
    task automatic pulse_relock();
        @(negedge refclk);
        bus.relock_req = 1'b1;
        @(posedge refclk); #1;
        bus.relock_req = 1'b0;
    endtask

    initial begin : stim
        int n, k, pulses, run, w, extra;
        bit prev, saw_sys, saw_wait;

        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        repeat (3) @(negedge refclk);
        rst_n = 1'b1;

        // 1: reset pulse width, lock-to-release latency
        n = 0;
        while (bus.pll_rst && n < 20) begin @(posedge refclk); #1; n++; end
        check_eq("s1_pll_rst_width", n, HOLD);
        repeat (5) @(negedge refclk);
        bus.pll_locked = 1'b1;
        n = 0;
        do begin @(posedge refclk); #1; n++; end while (!bus.sys_rst_n && n < 40);
        check_eq("s1_release_edges", n, 11);
        check_eq("s1_state", int'(bus.state), 3);

        // 2: no lock -> three pulses, then FAIL
        @(negedge refclk);
        bus.pll_locked = 1'b0;
        pulse_relock();
        k = 0; pulses = 0; run = 0; prev = 1'b0; saw_sys = 1'b0;
        while (!bus.fail && k < 200) begin
            if (bus.pll_rst) begin
                if (!prev) pulses++;
                run++;
            end else if (prev) begin
                check_eq("s2_pulse_width", run, HOLD);
                run = 0;
            end
            prev = bus.pll_rst;
            saw_sys |= bus.sys_rst_n;
            @(posedge refclk); #1; k++;
        end
        check_eq("s2_cycles_to_fail", k, 3 * (HOLD + TO));
        check_eq("s2_pulses", pulses, 3);
        check_eq("s2_sys_rst_n_seen", int'(saw_sys), 0);
        check_eq("s2_fail", int'(bus.fail), 1);
        check_eq("s2_state", int'(bus.state), 4);
        check_eq("s2_retry", int'(bus.retry_cnt), MR);

        // 3: glitch in STABILIZE after one timeout
        pulse_relock();
        n = 0;
        while (!(bus.retry_cnt == 1 && bus.state == StWaitLock) && n < 60) begin
            @(posedge refclk); #1; n++;
        end
        check_eq("s3_retry1_reached", int'(bus.retry_cnt == 1 && bus.state == StWaitLock), 1);
        @(negedge refclk);
        bus.pll_locked = 1'b1;
        wait_state(StStabilize, 10, "s3_stab");
        repeat (3) @(negedge refclk);
        bus.pll_locked = 1'b0;
        saw_wait = 1'b0; saw_sys = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge refclk); #1;
            saw_wait |= (bus.state == StWaitLock);
            saw_sys  |= bus.sys_rst_n;
            if (i == 3) bus.pll_locked = 1'b1;
        end
        check_eq("s3_back_to_wait", int'(saw_wait), 1);
        check_eq("s3_sys_rst_n_seen", int'(saw_sys), 0);
        n = 0;
        while (bus.state != StStabilize && n < 20) begin @(posedge refclk); #1; n++; end
        check_eq("s3_retry_kept", int'(bus.retry_cnt), 1);
        n = 0;
        while (bus.state != StRun && n < 30) begin @(posedge refclk); #1; n++; end
        check_eq("s3_stable_edges", n, STB);
        check_eq("s3_retry_cleared", int'(bus.retry_cnt), 0);

        // 4: lock loss in RUN, then saturation
        @(negedge refclk);
        bus.pll_locked = 1'b0;
        n = 0;
        while (bus.sys_rst_n && n < 10) begin @(posedge refclk); #1; n++; end
        check_eq("s4_loss_edges", n, SS + 1);
        check_eq("s4_pll_rst", int'(bus.pll_rst), 1);
        check_eq("s4_lost1", int'(bus.lock_lost_cnt), 1);
        for (int i = 0; i < 259; i++) begin
            @(negedge refclk);
            bus.pll_locked = 1'b1;
            wait_state(StRun, 60, "s4_run");
            repeat ($urandom_range(0, 4)) @(negedge refclk);
            bus.pll_locked = 1'b0;
            wait_state(StResetPll, 10, "s4_drop");
        end
        check_eq("s4_lost_sat", int'(bus.lock_lost_cnt), 255);

        // 5: recover from FAIL
        wait_state(StFail, 200, "s5_fail");
        pulse_relock();
        check_eq("s5_fail_cleared", int'(bus.fail), 0);
        check_eq("s5_retry_cleared", int'(bus.retry_cnt), 0);
        check_eq("s5_state", int'(bus.state), 0);
        bus.pll_locked = 1'b1;
        w = 0;
        while (bus.pll_rst && w < 20) begin w++; @(posedge refclk); #1; end
        check_eq("s5_pulse_width", w, HOLD);
        n = 0; extra = 0;
        while (bus.state != StRun && n < 60) begin
            @(posedge refclk); #1; n++;
            if (bus.pll_rst) extra++;
        end
        check_eq("s5_extra_rst", extra, 0);
        check_eq("s5_run", int'(bus.state), 3);

        // Random lock activity with occasional relock requests
        for (int seg = 0; seg < 40; seg++) begin
            bus.pll_locked = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 30)) begin
                @(negedge refclk);
                bus.relock_req = ($urandom_range(0, 40) == 0);
            end
        end
        @(negedge refclk);
        bus.relock_req = 1'b0;

        // 6: asynchronous reset between edges
        bus.pll_locked = 1'b1;
        pulse_relock();
        wait_state(StRun, 60, "s6_run");
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("s6_pll_rst", int'(bus.pll_rst), 1);
        check_eq("s6_sys_rst_n", int'(bus.sys_rst_n), 0);
        check_eq("s6_lost", int'(bus.lock_lost_cnt), 0);
        check_eq("s6_state", int'(bus.state), 0);
        repeat (3) @(negedge refclk);
        rst_n = 1'b1;
        repeat (30) @(negedge refclk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
